// File: rtl/led_matrix_top.sv
// HUB75 panel driver: raster pixel writes into a two-bank framebuffer, BCM scan-out of row pairs.
// Optional LED_MATRIX_DOUBLE_BUFFER_EN adds a front/back framebuffer swapped at refresh boundaries.
module led_matrix_top #(
    parameter int unsigned PANEL_ROWS  = 64,
    parameter int unsigned PANEL_COLS  = 64,
    parameter int unsigned COLOR_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [7:0]                          prescale,
    input  logic                                valid_in,
    input  logic [2:0][COLOR_DEPTH-1:0]         rgb_in,
    input  logic                                sync_in,
    output logic                                sync_out,
    output logic                                matrix_clk,
    output logic [$clog2(PANEL_ROWS/2)-1:0]     matrix_row,
    output logic [2:0]                          matrix_rgb_upper,
    output logic [2:0]                          matrix_rgb_lower,
    output logic                                matrix_oe_n,
    output logic                                matrix_stb
);
    localparam int unsigned HALF_ROWS = PANEL_ROWS / 2;
    localparam int unsigned ROW_W     = $clog2(HALF_ROWS);
    localparam int unsigned COL_W     = $clog2(PANEL_COLS);
    localparam int unsigned BANK_AW   = ROW_W + COL_W;
    localparam int unsigned ADDR_W    = BANK_AW + 1;
    localparam int unsigned PLANE_W   = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(2 * PANEL_COLS) + COLOR_DEPTH;

    typedef logic [2:0][COLOR_DEPTH-1:0] pix_t;
    typedef enum logic [1:0] {ST_SHIFT, ST_BLANK, ST_LATCH, ST_DISPLAY} state_t;

    // Write pointer; sync_in restarts the frame at pixel 0.
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] w_wr_addr;
    assign w_wr_addr = sync_in ? '0 : r_wptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
        end else if (sync_in) begin
            r_wptr <= valid_in ? ADDR_W'(1) : '0;
        end else if (valid_in) begin
            r_wptr <= r_wptr + ADDR_W'(1);
        end
    end

    // Scan tick divider; prescale of 0 behaves as 1.
    logic [7:0] r_div;
    logic [7:0] w_period;
    logic       w_tick;
    assign w_period = (prescale == 8'd0) ? 8'd1 : prescale;
    assign w_tick   = (r_div >= (w_period - 8'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 8'd1;
    end

    state_t               r_state;
    logic [ROW_W-1:0]     r_row;
    logic [PLANE_W-1:0]   r_plane;
    logic [COL_W-1:0]     r_col;
    logic                 r_phase;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_mclk, r_oe_n, r_stb, r_sync;
    logic [ROW_W-1:0]     r_mrow;
    logic [2:0]           r_rgb_upper, r_rgb_lower;
    pix_t                 r_pix_upper, r_pix_lower;

    logic                 w_last_col, w_last_plane, w_last_row;
    logic [CNT_W-1:0]     w_disp_len;
    logic [ROW_W-1:0]     w_next_row;
    logic [ROW_W-1:0]     w_rd_row;
    logic [COL_W-1:0]     w_rd_col;

    assign w_last_col   = (r_col == COL_W'(PANEL_COLS - 1));
    assign w_last_plane = (r_plane == PLANE_W'(COLOR_DEPTH - 1));
    assign w_last_row   = (r_row == ROW_W'(HALF_ROWS - 1));
    assign w_disp_len   = CNT_W'(2 * PANEL_COLS) << r_plane;
    assign w_next_row   = w_last_plane ? (r_row + ROW_W'(1)) : r_row;

    // Read-address prefetch: the RAM output is one cycle ahead of the shift tick that uses it.
    always_comb begin
        w_rd_row = r_row;
        w_rd_col = r_col;
        if (r_state == ST_DISPLAY) begin
            w_rd_row = w_next_row;
            w_rd_col = '0;
        end else if ((r_state == ST_SHIFT) && r_phase) begin
            w_rd_col = r_col + COL_W'(1);
        end
    end

`ifdef LED_MATRIX_DOUBLE_BUFFER_EN
    localparam int unsigned MEM_AW = BANK_AW + 1;
    logic              r_front, r_swap_req;
    logic              w_swap_req_new, w_refresh_done;
    logic [MEM_AW-1:0] w_wr_mem_addr, w_rd_mem_addr;

    assign w_swap_req_new = sync_in || (valid_in && (&r_wptr));
    assign w_refresh_done = w_tick && (r_state == ST_DISPLAY) && (r_cnt == w_disp_len)
                            && w_last_plane && w_last_row;
    assign w_wr_mem_addr  = {~r_front, w_wr_addr[BANK_AW-1:0]};
    assign w_rd_mem_addr  = {r_front, w_rd_row, w_rd_col};

    // Pending swap is honoured only on the refresh-complete cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front    <= 1'b0;
            r_swap_req <= 1'b0;
        end else if (w_refresh_done && r_swap_req) begin
            r_front    <= ~r_front;
            r_swap_req <= w_swap_req_new;
        end else if (w_swap_req_new) begin
            r_swap_req <= 1'b1;
        end
    end
`else
    localparam int unsigned MEM_AW = BANK_AW;
    logic [MEM_AW-1:0] w_wr_mem_addr, w_rd_mem_addr;
    assign w_wr_mem_addr = w_wr_addr[BANK_AW-1:0];
    assign w_rd_mem_addr = {w_rd_row, w_rd_col};
`endif

    pix_t r_mem_upper [1 << MEM_AW];
    pix_t r_mem_lower [1 << MEM_AW];

    // Framebuffer banks, split on the row MSB, with registered reads.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            if (w_wr_addr[ADDR_W-1]) r_mem_lower[w_wr_mem_addr] <= rgb_in;
            else                     r_mem_upper[w_wr_mem_addr] <= rgb_in;
        end
        r_pix_upper <= r_mem_upper[w_rd_mem_addr];
        r_pix_lower <= r_mem_lower[w_rd_mem_addr];
    end

    // Scan engine: shift a plane of a row pair, blank, latch, then display for a BCM-weighted time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SHIFT;
            r_row       <= '0;
            r_plane     <= '0;
            r_col       <= '0;
            r_phase     <= 1'b0;
            r_cnt       <= '0;
            r_mclk      <= 1'b0;
            r_mrow      <= '0;
            r_rgb_upper <= '0;
            r_rgb_lower <= '0;
            r_oe_n      <= 1'b1;
            r_stb       <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_SHIFT: begin
                        if (!r_phase) begin
                            r_mclk      <= 1'b0;
                            r_rgb_upper <= {r_pix_upper[2][r_plane], r_pix_upper[1][r_plane],
                                            r_pix_upper[0][r_plane]};
                            r_rgb_lower <= {r_pix_lower[2][r_plane], r_pix_lower[1][r_plane],
                                            r_pix_lower[0][r_plane]};
                            r_phase     <= 1'b1;
                        end else begin
                            r_mclk  <= 1'b1;
                            r_phase <= 1'b0;
                            r_col   <= r_col + COL_W'(1);
                            if (w_last_col) r_state <= ST_BLANK;
                        end
                    end
                    ST_BLANK: begin
                        r_mclk  <= 1'b0;
                        r_oe_n  <= 1'b1;
                        r_state <= ST_LATCH;
                    end
                    ST_LATCH: begin
                        r_stb   <= 1'b1;
                        r_mrow  <= r_row;
                        r_cnt   <= '0;
                        r_state <= ST_DISPLAY;
                    end
                    ST_DISPLAY: begin
                        r_stb <= 1'b0;
                        if (r_cnt == w_disp_len) begin
                            r_oe_n  <= 1'b1;
                            r_state <= ST_SHIFT;
                            r_row   <= w_next_row;
                            r_plane <= w_last_plane ? '0 : (r_plane + PLANE_W'(1));
                            if (w_last_plane && w_last_row) r_sync <= 1'b1;
                        end else begin
                            r_oe_n <= 1'b0;
                            r_cnt  <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= ST_SHIFT;
                endcase
            end
        end
    end

    assign sync_out         = r_sync;
    assign matrix_clk       = r_mclk;
    assign matrix_row       = r_mrow;
    assign matrix_rgb_upper = r_rgb_upper;
    assign matrix_rgb_lower = r_rgb_lower;
    assign matrix_oe_n      = r_oe_n;
    assign matrix_stb       = r_stb;
endmodule

// File: tb/tb_led_matrix_top.sv
// Directed bench for led_matrix_top: fills the framebuffer, captures one full refresh, checks pixels and timing.
module tb_led_matrix_top;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       prescale;
    logic             valid_in;
    logic [2:0][3:0]  rgb_in;
    logic             sync_in;
    logic             sync_out, matrix_clk, matrix_oe_n, matrix_stb;
    logic [4:0]       matrix_row;
    logic [2:0]       matrix_rgb_upper, matrix_rgb_lower;

    led_matrix_top dut (
        .clk(clk), .rst_n(rst_n), .prescale(prescale), .valid_in(valid_in),
        .rgb_in(rgb_in), .sync_in(sync_in), .sync_out(sync_out),
        .matrix_clk(matrix_clk), .matrix_row(matrix_row),
        .matrix_rgb_upper(matrix_rgb_upper), .matrix_rgb_lower(matrix_rgb_lower),
        .matrix_oe_n(matrix_oe_n), .matrix_stb(matrix_stb)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         plane;
        int         row;
        int         col;
        logic [2:0] exp_u;
        logic [2:0] exp_l;
    } vec_t;

    logic [11:0] fb [4096];
    logic [2:0]  cap_u [4][32][64];
    logic [2:0]  cap_l [4][32][64];
    logic [2:0]  line_u [64];
    logic [2:0]  line_l [64];

    // Panel-side monitor state
    bit mon_en = 0;
    int exp_ps = 1;
    int cyc = 0, s = 0, col_cnt = 0, oe_cnt = 0, oe_chk = 0, sync_cnt = 0, viol = 0;
    int first_rise = 0, last_rise = 0, seq_ps = 1, seq_plane = 0;
    logic prev_mclk = 0, prev_stb = 0, prev_oe = 1;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            s = 0; col_cnt = 0; oe_cnt = 0;
            prev_mclk = 0; prev_stb = 0; prev_oe = 1;
        end else if (mon_en) begin
            if (matrix_clk && !prev_mclk) begin
                if (col_cnt == 0) first_rise = cyc;
                last_rise = cyc;
                if (col_cnt < 64) begin
                    line_u[col_cnt] = matrix_rgb_upper;
                    line_l[col_cnt] = matrix_rgb_lower;
                end
                col_cnt++;
            end
            if (matrix_stb && !prev_stb) begin
                seq_ps = exp_ps;
                check("shift_edges", col_cnt, 64);
                check("latched_row", int'(matrix_row), (s / 4) % 32);
                check("shift_span", last_rise - first_rise, 126 * seq_ps);
                if (s < 128)
                    for (int c = 0; c < 64; c++) begin
                        cap_u[s % 4][s / 4][c] = line_u[c];
                        cap_l[s % 4][s / 4][c] = line_l[c];
                    end
                seq_plane = s % 4;
                s++;
                col_cnt = 0;
            end
            if (!matrix_oe_n) oe_cnt++;
            if (matrix_oe_n && !prev_oe) begin
                check("oe_low_len", oe_cnt, (128 << seq_plane) * seq_ps);
                oe_cnt = 0;
                oe_chk++;
            end
            if (matrix_stb && !matrix_oe_n) viol++;
            if (sync_out) begin
                check("sync_after_seq", s, 128);
                sync_cnt++;
            end
            prev_mclk = matrix_clk;
            prev_stb  = matrix_stb;
            prev_oe   = matrix_oe_n;
        end
    end

    task automatic put_pix(input logic [11:0] v, input logic sync);
        valid_in = 1'b1;
        rgb_in   = v;
        sync_in  = sync;
        @(negedge clk);
        valid_in = 1'b0;
        sync_in  = 1'b0;
    endtask

    initial begin
        vec_t tbl[22];
        int   bad;
        bit   got;
        logic [11:0] pu, pl;
        logic [2:0]  eu, el;

        tbl = '{
            '{0, 0,  0, 3'b000, 3'b000}, '{0, 0,  1, 3'b001, 3'b000},
            '{0, 0,  2, 3'b000, 3'b000}, '{0, 0, 15, 3'b001, 3'b000},
            '{1, 0,  2, 3'b001, 3'b000}, '{1, 0,  5, 3'b000, 3'b000},
            '{2, 0,  5, 3'b001, 3'b000}, '{3, 0,  7, 3'b000, 3'b000},
            '{3, 0,  8, 3'b001, 3'b000}, '{3, 0, 15, 3'b001, 3'b000},
            '{3, 0, 16, 3'b000, 3'b000}, '{3, 0, 31, 3'b010, 3'b000},
            '{3, 0, 32, 3'b010, 3'b000}, '{3, 0, 33, 3'b000, 3'b000},
            '{2, 0, 31, 3'b000, 3'b000}, '{0, 0, 56, 3'b100, 3'b000},
            '{2, 0, 63, 3'b100, 3'b000}, '{1, 0, 55, 3'b000, 3'b000},
            '{0, 31, 0, 3'b000, 3'b111}, '{3, 31, 63, 3'b000, 3'b111},
            '{2, 15, 20, 3'b000, 3'b000}, '{0, 1, 0, 3'b000, 3'b000}
        };

        for (int a = 0; a < 4096; a++) begin
            fb[a] = 12'h000;
            if (a < 16)                 fb[a] = 12'(a);
            if (a == 31 || a == 32)     fb[a] = 12'h080;
            if (a >= 56 && a <= 63)     fb[a] = 12'hF00;
            if (a >= 4032)              fb[a] = 12'hFFF;
        end

        rst_n = 1'b0; prescale = 8'd1; valid_in = 1'b0; sync_in = 1'b0; rgb_in = '0;
        repeat (25) @(negedge clk);
        check("rst_oe_n",  int'(matrix_oe_n), 1);
        check("rst_stb",   int'(matrix_stb), 0);
        check("rst_mclk",  int'(matrix_clk), 0);
        check("rst_row",   int'(matrix_row), 0);
        check("rst_sync",  int'(sync_out), 0);
        check("rst_rgb_u", int'(matrix_rgb_upper), 0);
        check("rst_rgb_l", int'(matrix_rgb_lower), 0);

        // Fill with a slow scan: junk, bare sync, more junk, then the frame starting with sync+valid.
        prescale = 8'd255;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 100; i++) put_pix(12'hABC, 1'b0);
        sync_in = 1'b1;
        @(negedge clk);
        sync_in = 1'b0;
        for (int i = 0; i < 50; i++) put_pix(12'h5A5, 1'b0);
        put_pix(fb[0], 1'b1);
        for (int a = 1; a < 4096; a++) put_pix(fb[a], 1'b0);

        // Restart the scan from reset; framebuffer contents survive.
        rst_n = 1'b0;
        #1;
        check("async_rst_mclk", int'(matrix_clk), 0);
        check("async_rst_oe_n", int'(matrix_oe_n), 1);
        repeat (25) @(negedge clk);
        prescale = 8'd1;
        exp_ps   = 1;
        mon_en   = 1;
        rst_n    = 1'b1;

        got = 0;
        for (int i = 0; i < 90000 && !got; i++) begin
            @(negedge clk);
            if (sync_out) got = 1;
        end
        prescale = 8'd3;
        exp_ps   = 3;
        check("sync_seen", int'(got), 1);

        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (oe_chk >= 129) got = 1;
        end
        check("ps3_seq_done", int'(got), 1);

        got = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (!matrix_oe_n) got = 1;
        end
        check("ps3_display_seen", int'(got), 1);
        mon_en = 0;
        #2 rst_n = 1'b0;
        #1;
        check("midscan_rst_oe_n", int'(matrix_oe_n), 1);
        check("midscan_rst_stb",  int'(matrix_stb), 0);
        check("midscan_rst_mclk", int'(matrix_clk), 0);
        check("midscan_rst_row",  int'(matrix_row), 0);

        check("sync_pulses", sync_cnt, 1);
        check("stb_oe_overlap", viol, 0);

        for (int i = 0; i < 22; i++) begin
            check($sformatf("pix_u p%0d r%0d c%0d", tbl[i].plane, tbl[i].row, tbl[i].col),
                  int'(cap_u[tbl[i].plane][tbl[i].row][tbl[i].col]), int'(tbl[i].exp_u));
            check($sformatf("pix_l p%0d r%0d c%0d", tbl[i].plane, tbl[i].row, tbl[i].col),
                  int'(cap_l[tbl[i].plane][tbl[i].row][tbl[i].col]), int'(tbl[i].exp_l));
        end

        bad = 0;
        for (int p = 0; p < 4; p++)
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 64; c++) begin
                    pu = fb[r * 64 + c];
                    pl = fb[(r + 32) * 64 + c];
                    eu = {pu[8 + p], pu[4 + p], pu[p]};
                    el = {pl[8 + p], pl[4 + p], pl[p]};
                    if (cap_u[p][r][c] !== eu || cap_l[p][r][c] !== el) bad++;
                end
        check("full_frame_bad_pixels", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/led_matrix_top.md
Name: led_matrix_top

Overview:
Drives a HUB75-style RGB LED panel from a raster pixel stream. Pixels are written into an internal framebuffer. A scan engine reads the framebuffer back and shifts two rows at a time (upper and lower half) into the panel. Brightness uses binary-coded modulation over COLOR_DEPTH bit planes. The block sits between the pixel source (SPI/Wi-Fi frame receiver) and the panel connector.

Parameters:
PANEL_ROWS, 64, panel height in pixels; even; PANEL_ROWS/2 must be a power of two.
PANEL_COLS, 64, panel width in pixels; power of two.
COLOR_DEPTH, 4, bits per colour channel; equals the number of bit planes.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
prescale  in  8  scan tick divider; one tick every max(prescale,1) clk cycles.
valid_in  in  1  rgb_in holds a pixel this cycle.
rgb_in  in  [2:0][COLOR_DEPTH-1:0]  pixel; [2]=R, [1]=G, [0]=B.
sync_in  in  1  frame start; forces write pointer to pixel 0.
sync_out  out  1  one-cycle pulse when a full refresh (all row pairs, all planes) completes.
matrix_clk  out  1  panel shift clock.
matrix_row  out  $clog2(PANEL_ROWS/2)  row-pair address (5 bits at default).
matrix_rgb_upper  out  3  {R,G,B} for row matrix_row.
matrix_rgb_lower  out  3  {R,G,B} for row matrix_row+PANEL_ROWS/2.
matrix_oe_n  out  1  panel output enable, active low.
matrix_stb  out  1  panel latch strobe, active high.

Behaviour:
- Reset: write pointer 0; scan at row 0, plane 0, column 0, state SHIFT. Outputs: matrix_clk=0, matrix_row=0, rgb outputs 0, matrix_oe_n=1, matrix_stb=0, sync_out=0. Framebuffer contents are not reset.
- Write side:
  - Pixel address = row*PANEL_COLS+col, raster order.
  - On valid_in, write rgb_in at the pointer, then increment.
  - The pointer wraps from PANEL_ROWS*PANEL_COLS-1 to 0.
  - sync_in sets the pointer to 0. If valid_in is also high that cycle, the pixel goes to address 0 and the pointer becomes 1.
- Storage: two banks. The upper bank holds rows 0..PANEL_ROWS/2-1; the lower bank holds the remaining rows, selected by the address MSB. Each bank gives 1-cycle synchronous read latency. Both banks are read at the same column each column step.
- Tick: free-running counter in clk; it pulses once every max(prescale,1) cycles. prescale is sampled live. All scan state changes happen only on tick.
- Scan FSM, one plane b of one row pair r:
  - SHIFT: for each column c = 0..PANEL_COLS-1:
    - Tick 1: matrix_clk=0; matrix_rgb_upper/lower = bit b of each channel of pixel (r,c) / (r+PANEL_ROWS/2,c).
    - Tick 2: matrix_clk=1; the panel samples on this rising edge.
    - Read-address prefetch hides the RAM latency.
  - BLANK (1 tick): matrix_clk=0, matrix_oe_n=1.
  - LATCH (1 tick): matrix_stb=1; matrix_row updates to r.
  - DISPLAY: matrix_stb=0, matrix_oe_n=0 for (2*PANEL_COLS)<<b ticks.
  - Then matrix_oe_n=1. Advance b. After the last plane, set b=0 and advance r. After the last r, set r=0 and pulse sync_out for one clk cycle.
- matrix_oe_n stays high in every state except DISPLAY. matrix_stb is never high while matrix_oe_n is low.
- Writes may collide with scan reads. The panel then shows mixed old/new data for that refresh; this is acceptable (no tearing protection without the optional feature).
- Asserting rst_n low mid-scan returns everything to reset state immediately.

Optional Feature:
LED_MATRIX_DOUBLE_BUFFER_EN:
- Defined: two framebuffer copies. Writes go to the back copy and the scan reads the front copy. A swap is requested when sync_in is seen or the write pointer wraps. The swap takes effect only at the refresh boundary (the cycle sync_out pulses), so no refresh mixes frames.
- Undefined: a single framebuffer as described in Behaviour.

Test Plan:
- Reset: hold rst_n low 25 cycles → matrix_oe_n=1, matrix_stb=0, matrix_clk=0, matrix_row=0, sync_out=0.
- Write pixels k=0..15 with value k, all others 0, prescale=1; plane 0, row 0 → matrix_rgb_upper[0] = k[0] for columns 0..15 (0,1,0,1…); plane 3 → columns 8..15 show B=1.
- Pixels 31,32 = 12'h080, plane 3 → matrix_rgb_upper=3'b010 at columns 31,32 only; pixels 56..63 = 12'hF00 → 3'b100 on row 0, columns 56..63, all planes.
- Pixels 4032..4095 = 12'hFFF → row pair 31: matrix_rgb_lower=3'b111 on all 64 columns, matrix_rgb_upper=0; matrix_row=31 after that LATCH.
- Timing, prescale=1: count per row/plane → exactly 64 matrix_clk rising edges, one matrix_stb pulse, then matrix_oe_n low for 128<<b cycles. prescale=3 → all durations ×3.
- Mid-stream sync_in after 100 pixels → the next pixel is written at address 0. Full refresh completes → exactly one sync_out pulse per 32 row pairs × 4 planes.
